// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 4:1 round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {ARB, LOCK} arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority search: first set req bit starting at ptr, wrapping mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gsel,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        gsel = ptr;
        any  = 1'b0;
        idx  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                gsel = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Four valid/ready requesters share one registered 4:1 mux; round-robin, packet-locked grant.
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] in_valid,
    input  logic [N_REQ-1:0] in_last,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [N_REQ-1:0] in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_last,
    input  logic             out_ready
);

    arb_state_t       state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] lock_sel_q;

    logic [SEL_W-1:0] pick_sel;
    logic             pick_any;
    logic [SEL_W-1:0] gsel;
    logic             any_grantable;
    logic             load;
    logic [WIDTH-1:0] mux_data;

    rr_pick4 u_pick (
        .req  (in_valid),
        .ptr  (ptr_q),
        .gsel (pick_sel),
        .any  (pick_any)
    );

    // While locked, only the owning requester's valid matters.
    always_comb begin
        if (state_q == LOCK) begin
            gsel          = lock_sel_q;
            any_grantable = in_valid[lock_sel_q];
        end else begin
            gsel          = pick_sel;
            any_grantable = pick_any;
        end
    end

    assign load = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (load && any_grantable) begin
            in_ready[gsel] = 1'b1;
        end
    end

    always_comb begin
        unique case (gsel)
            2'd0:    mux_data = in_data0;
            2'd1:    mux_data = in_data1;
            2'd2:    mux_data = in_data2;
            default: mux_data = in_data3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            lock_sel_q <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            out_last   <= 1'b0;
        end else if (load) begin
            if (any_grantable) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_sel   <= gsel;
                out_last  <= in_last[gsel];
                if (in_last[gsel]) begin
                    state_q <= ARB;
                    ptr_q   <= gsel + 2'd1;
                end else if (state_q == ARB) begin
                    state_q    <= LOCK;
                    lock_sel_q <= gsel;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench with an expected-beat scoreboard for mux_4_1_rr_arbiter.
module tb_mux_4_1_rr_arbiter;

    localparam int unsigned WIDTH = 4;

    typedef struct {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [3:0]       in_last;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_last;
    logic             out_ready;

    int checks   = 0;
    int failures = 0;
    beat_t exp_q[$];

    mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic [WIDTH-1:0] data, input logic last);
        beat_t b;
        b.sel  = sel;
        b.data = data;
        b.last = last;
        exp_q.push_back(b);
    endtask

    // Sink side: a beat presented with out_ready high is consumed at the coming edge.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_beat observed sel=%0d data=%0h expected none",
                       out_sel, out_data);
            end else begin
                b = exp_q.pop_front();
                chk("sb_sel", 32'(out_sel), 32'(b.sel));
                chk("sb_data", 32'(out_data), 32'(b.data));
                chk("sb_last", 32'(out_last), 32'(b.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data0  = '0;
        in_data1  = '0;
        in_data2  = '0;
        in_data3  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 32'(in_ready), 32'(exp));
    endtask

    initial begin
        // Fairness: all valid, single-beat packets.
        do_reset();
        in_data0 = 4'h5; in_data1 = 4'hA; in_data2 = 4'h3; in_data3 = 4'hC;
        in_last  = 4'b1111;
        in_valid = 4'b1111;
        push(2'd0, 4'h5, 1'b1); push(2'd1, 4'hA, 1'b1); push(2'd2, 4'h3, 1'b1);
        push(2'd3, 4'hC, 1'b1); push(2'd0, 4'h5, 1'b1); push(2'd1, 4'hA, 1'b1);
        chk_ready("fair_ready0", 4'b0001);
        for (int i = 0; i < 6; i++) tick();
        in_valid = '0;
        tick();
        chk("fair_idle_valid", 32'(out_valid), 32'd0);

        // Packet lock: req1 three beats, req2 waiting.
        do_reset();
        in_valid = 4'b0110;
        in_last  = 4'b0100;
        in_data1 = 4'h1; in_data2 = 4'h9;
        push(2'd1, 4'h1, 1'b0); push(2'd1, 4'h2, 1'b0);
        push(2'd1, 4'h3, 1'b1); push(2'd2, 4'h9, 1'b1);
        chk_ready("lock_ready_b1", 4'b0010);
        tick();
        in_data1 = 4'h2;
        chk_ready("lock_ready_b2", 4'b0010);
        tick();
        in_data1 = 4'h3;
        in_last  = 4'b0110;
        chk_ready("lock_ready_b3", 4'b0010);
        tick();
        in_valid = 4'b0100;
        chk_ready("lock_ready_req2", 4'b0100);
        tick();
        in_valid = '0;
        tick();

        // Backpressure: output held, no accepts, then resumes.
        do_reset();
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        in_data0 = 4'h7;
        push(2'd0, 4'h7, 1'b1); push(2'd0, 4'h8, 1'b1);
        tick();
        in_data0  = 4'h8;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ready("bp_ready", 4'b0000);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h7);
            chk("bp_sel", 32'(out_sel), 32'd0);
        end
        out_ready = 1'b1;
        chk_ready("bp_ready_resume", 4'b0001);
        tick();
        chk("bp_next_data", 32'(out_data), 32'h8);
        in_valid = '0;
        tick();

        // Sparse wrap: req3 alone, then req0 beats req3 at ptr=0.
        do_reset();
        in_valid = 4'b1000;
        in_last  = 4'b1001;
        in_data3 = 4'hC; in_data0 = 4'h4;
        push(2'd3, 4'hC, 1'b1); push(2'd0, 4'h4, 1'b1); push(2'd3, 4'hC, 1'b1);
        chk_ready("wrap_ready3", 4'b1000);
        tick();
        in_valid = 4'b1001;
        chk_ready("wrap_ready0", 4'b0001);
        tick();
        in_valid = 4'b1000;
        chk_ready("wrap_ready3b", 4'b1000);
        tick();
        in_valid = '0;
        tick();

        // Lock bubble on req2 while req0 waits.
        do_reset();
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        in_data2 = 4'h1; in_data0 = 4'h5; in_data3 = 4'hD;
        push(2'd2, 4'h1, 1'b0); push(2'd2, 4'h2, 1'b1);
        push(2'd3, 4'hD, 1'b1); push(2'd0, 4'h5, 1'b1);
        tick();
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            chk_ready("bub_ready", 4'b0000);
            tick();
            chk("bub_out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 4'b0101;
        in_last  = 4'b1101;
        in_data2 = 4'h2;
        chk_ready("bub_resume", 4'b0100);
        tick();
        in_valid = 4'b1001;
        chk_ready("bub_ptr3", 4'b1000);
        tick();
        in_valid = 4'b0001;
        chk_ready("bub_req0", 4'b0001);
        tick();
        in_valid = '0;
        tick();

        // Asynchronous reset in the middle of a locked packet.
        do_reset();
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        in_data1 = 4'h6;
        tick();
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_sel", 32'(out_sel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0011;
        in_data0 = 4'hA;
        push(2'd0, 4'hA, 1'b1); push(2'd1, 4'h6, 1'b1);
        chk_ready("ar_req0_prio", 4'b0001);
        tick();
        in_valid = 4'b0010;
        chk_ready("ar_req1", 4'b0010);
        tick();
        in_valid = '0;
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
